oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- OAM DMA engine plus bus arbiter for the GBC memory path.
- A CPU write to the DMA I/O register (0xFF46) copies DMA_LEN bytes from {src_hi, 8'h00} to DEST_BASE (OAM, 0xFE00).
- Sits between the CPU and the memory router, which fronts WRAM/ROM/VRAM/OAM. Owns the router bus while a transfer runs; passes CPU traffic through otherwise.

Parameters:
DMA_LEN, 160, bytes per transfer (index 0..DMA_LEN-1, max 256)
DEST_BASE, 16'hFE00, destination base address
BYTE_CYCLES, 4, I_CLK cycles per byte slot (min 4)

Ports:
I_CLK  in  1  system clock
I_RESET  in  1  synchronous active-high reset
I_IOREG_ADDR  in  16  I/O register bus address
I_IOREG_WDATA  in  8  I/O register write data
I_IOREG_WE_L  in  1  I/O write strobe, active low
I_IOREG_RE_L  in  1  I/O read strobe, active low
O_IOREG_RDATA  out  8  DMA register readback; 8'hFF when not addressed
I_CPU_ADDR  in  16  CPU memory address
I_CPU_WDATA  in  8  CPU write data
I_CPU_WE_L  in  1  CPU write strobe, active low
I_CPU_RE_L  in  1  CPU read strobe, active low
O_CPU_RDATA  out  8  data returned to CPU
O_MEM_ADDR  out  16  router address
O_MEM_WDATA  out  8  router write data
O_MEM_WE_L  out  1  router write strobe, active low
O_MEM_RE_L  out  1  router read strobe, active low
I_MEM_RDATA  in  8  router read data, valid 1 clock after O_MEM_RE_L low
O_DMA_ACTIVE  out  1  high while the engine owns the router bus

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is synchronous and active-high on I_RESET.
- Reset values:
  - state=IDLE; dma_reg=8'hFF; index=0; phase=0; O_DMA_ACTIVE=0.
  - O_MEM_WE_L=1, O_MEM_RE_L=1, O_MEM_ADDR=0, O_MEM_WDATA=0; O_CPU_RDATA=8'hFF.
- Reset mid-transfer: abort on the next edge. No further OAM writes occur.
- Register access:
  - Write when I_IOREG_ADDR==0xFF46 and I_IOREG_WE_L low at a rising edge. This sets dma_reg and state=START, phase=0, index=0.
  - Reads of 0xFF46 return dma_reg combinationally.
- Source address: src_hi = dma_reg, except dma_reg>=8'hE0 uses dma_reg-8'h20 (echo RAM folding). Source = {src_hi, index}.
- States:
  - IDLE: CPU passthrough. O_MEM_* = CPU signals, O_CPU_RDATA = I_MEM_RDATA.
  - START: one byte slot (BYTE_CYCLES clocks), bus idle, then XFER.
  - XFER: per byte slot, indexed by phase 0..BYTE_CYCLES-1.
    - phase0: O_MEM_RE_L=0, addr=source.
    - phase1: latch I_MEM_RDATA into dma_byte.
    - phase2: O_MEM_WE_L=0, addr=DEST_BASE+index, wdata=dma_byte.
    - phase>=3: idle.
    - At the last phase: if index==DMA_LEN-1, go to IDLE; else index+1.
- O_DMA_ACTIVE: high in START and XFER. Total active time is (DMA_LEN+1)*BYTE_CYCLES clocks (644 with defaults).
- CPU blocking while active:
  - CPU strobes are not forwarded; CPU writes are dropped.
  - CPU reads return 8'hFF.
  - Addresses 0xFF00-0xFFFF (I/O, HRAM) are never forwarded by this block, in any state. They are serviced on the I/O bus.
- Restart: a write to 0xFF46 while active reloads dma_reg and restarts from START with index=0. An in-flight phase2 write in the same cycle still completes. O_DMA_ACTIVE stays high without a gap.
- Simultaneous events: a register write in the final slot wins over the return to IDLE.

Optional Feature:
- Macro: OAM_DMA_BUS_CONFLICT_EN.
- Defined: CPU reads during START/XFER return dma_byte (the last byte fetched by the engine), modelling bus conflict.
- Undefined: CPU reads during START/XFER return 8'hFF.

Decomposition:
- memdef.vh holds:
  - `DMA (16'hFF46), `OAM_BASE (16'hFE00), `ECHO_FOLD_THRESH (8'hE0).
  - State encodings `DMA_IDLE/`DMA_START/`DMA_XFER.
- One sub-module: dma_byte_sequencer. It holds the phase and index counters and the slot/last-byte flags. The arbiter mux and register stay in the top.

Test Plan:
- Write 8'hC1 to 0xFF46 with WRAM 0xC100..0xC19F preloaded with i^8'h5A -> OAM 0xFE00..0xFE9F contain the same bytes. O_DMA_ACTIVE high for exactly 644 clocks.
- Write 8'hE2 -> source reads hit 0xC200..0xC29F (echo fold). Read 0xFF46 -> 8'hE2.
- CPU writes 0x77 to 0xC000 mid-transfer -> 0xC000 unchanged. CPU read of 0xD000 -> 8'hFF (macro off) or the current dma_byte (macro on).
- Restart at index 50 with 8'hC3 -> final OAM holds 0xC300.. data. O_DMA_ACTIVE never drops. Total active time is 50*4+4+644 clocks from the first write.
- Assert I_RESET at index 80 -> next cycle idle, O_DMA_ACTIVE=0, dma_reg=8'hFF. OAM 0xFE50 onward untouched.
- Idle passthrough: CPU read 0xC005 -> O_MEM_RE_L low with addr 0xC005. CPU access to 0xFF80 -> O_MEM strobes stay high.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// ----------------------------------------------------------------------------
// oam_dma_controller_pkg
//   Shared constants, state encoding and the echo-RAM source folding helper
//   for the OAM DMA engine and its byte sequencer.
// ----------------------------------------------------------------------------
package oam_dma_controller_pkg;

    localparam logic [15:0] DMA_REG_ADDR        = 16'hFF46;  // DMA I/O register
    localparam logic [15:0] OAM_BASE            = 16'hFE00;  // sprite attribute table
    localparam logic [7:0]  ECHO_FOLD_THRESH    = 8'hE0;     // first echo-RAM page
    localparam logic [7:0]  IO_PAGE             = 8'hFF;     // I/O + HRAM page, never routed here

    localparam int          DMA_LEN_DEFAULT     = 160;
    localparam logic [15:0] DEST_BASE_DEFAULT   = OAM_BASE;
    localparam int          BYTE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_t;

    // Pages 0xE0..0xFF mirror WRAM at 0xC0..0xDF, so fetch from the mirror.
    function automatic logic [7:0] fold_src_hi(input logic [7:0] reg_val);
        return (reg_val >= ECHO_FOLD_THRESH) ? (reg_val - 8'h20) : reg_val;
    endfunction

endpackage

// File: rtl/oam_dma_controller_dma_byte_sequencer.sv
// ----------------------------------------------------------------------------
// dma_byte_sequencer
//   Phase and byte-index counters for the OAM DMA engine. The phase counter
//   walks 0..BYTE_CYCLES-1 inside each byte slot; the index advances at the
//   end of every transfer slot and wraps to 0 after the last byte.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   restart     DMA register written: clear both counters
//   run         engine active (START or XFER): phase counter runs
//   step_index  transfer slots in progress (XFER): index advances per slot
//   phase       position within the current byte slot
//   index       byte index within the transfer
//   slot_end    current cycle is the last phase of a slot
//   last_byte   index is the final byte of the transfer
// ----------------------------------------------------------------------------
module dma_byte_sequencer
    import oam_dma_controller_pkg::*;
#(
    parameter int DMA_LEN     = DMA_LEN_DEFAULT,
    parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           restart,
    input  logic                           run,
    input  logic                           step_index,
    output logic [$clog2(BYTE_CYCLES)-1:0] phase,
    output logic [7:0]                     index,
    output logic                           slot_end,
    output logic                           last_byte
);

    localparam int PHASE_W = $clog2(BYTE_CYCLES);

    assign slot_end  = (phase == PHASE_W'(BYTE_CYCLES - 1));
    assign last_byte = (index == 8'(DMA_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            phase <= '0;
            index <= '0;
        end else if (run) begin
            if (slot_end) begin
                phase <= '0;
                if (step_index) begin
                    index <= last_byte ? 8'h00 : (index + 8'h01);
                end
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// ----------------------------------------------------------------------------
// oam_dma_controller
//   OAM DMA engine plus router-bus arbiter. A write to 0xFF46 copies DMA_LEN
//   bytes from {src_hi, 8'h00} to DEST_BASE, one byte per BYTE_CYCLES slot,
//   after a one-slot START delay. While the engine is active the CPU is cut
//   off from the router; otherwise CPU traffic passes straight through.
//   CPU accesses to 0xFF00..0xFFFF are never forwarded.
//
// Build option:
//   OAM_DMA_BUS_CONFLICT_EN  when defined, CPU reads during START/XFER return
//                            the last byte fetched by the engine instead of
//                            8'hFF.
//
// Ports:
//   I_CLK, I_RESET                 clock, synchronous active-high reset
//   I_IOREG_ADDR/WDATA/WE_L/RE_L   I/O register bus (strobes active low)
//   O_IOREG_RDATA                  dma_reg when 0xFF46 is read, else 8'hFF
//   I_CPU_ADDR/WDATA/WE_L/RE_L     CPU memory request
//   O_CPU_RDATA                    data returned to the CPU
//   O_MEM_ADDR/WDATA/WE_L/RE_L     router request (strobes active low)
//   I_MEM_RDATA                    router read data, one clock after RE_L
//   O_DMA_ACTIVE                   engine owns the router bus
// ----------------------------------------------------------------------------
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter int          DMA_LEN     = DMA_LEN_DEFAULT,
    parameter logic [15:0] DEST_BASE   = DEST_BASE_DEFAULT,
    parameter int          BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_IOREG_ADDR,
    input  logic [7:0]  I_IOREG_WDATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    output logic [7:0]  O_IOREG_RDATA,
    input  logic [15:0] I_CPU_ADDR,
    input  logic [7:0]  I_CPU_WDATA,
    input  logic        I_CPU_WE_L,
    input  logic        I_CPU_RE_L,
    output logic [7:0]  O_CPU_RDATA,
    output logic [15:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_WDATA,
    output logic        O_MEM_WE_L,
    output logic        O_MEM_RE_L,
    input  logic [7:0]  I_MEM_RDATA,
    output logic        O_DMA_ACTIVE
);

    localparam int PHASE_W = $clog2(BYTE_CYCLES);

    dma_state_t          state;
    dma_state_t          state_next;
    logic [7:0]          dma_reg;
    logic [7:0]          dma_byte;
    logic [7:0]          index;
    logic [PHASE_W-1:0]  phase;
    logic                slot_end;
    logic                last_byte;
    logic                reg_write;
    logic                cpu_is_io;
    logic [15:0]         src_addr;
    logic [15:0]         dest_addr;
    logic [7:0]          blocked_rdata;

    assign reg_write = (I_IOREG_ADDR == DMA_REG_ADDR) && !I_IOREG_WE_L;
    assign cpu_is_io = (I_CPU_ADDR[15:8] == IO_PAGE);
    assign src_addr  = {fold_src_hi(dma_reg), index};
    assign dest_addr = DEST_BASE + {8'h00, index};

    assign O_IOREG_RDATA = ((I_IOREG_ADDR == DMA_REG_ADDR) && !I_IOREG_RE_L) ? dma_reg : 8'hFF;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign blocked_rdata = dma_byte;
`else
    assign blocked_rdata = 8'hFF;
`endif

    dma_byte_sequencer #(
        .DMA_LEN     (DMA_LEN),
        .BYTE_CYCLES (BYTE_CYCLES)
    ) u_seq (
        .clk        (I_CLK),
        .rst        (I_RESET),
        .restart    (reg_write),
        .run        (state != DMA_IDLE),
        .step_index (state == DMA_XFER),
        .phase      (phase),
        .index      (index),
        .slot_end   (slot_end),
        .last_byte  (last_byte)
    );

    // ---------------------------------------------------------------- state
    // NOTE: every clocked block uses <= so all registers sample the same
    // pre-edge values; a blocking = here would leak this cycle's update into
    // other flops depending on process ordering.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned; otherwise always_comb would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            DMA_IDLE:  state_next = DMA_IDLE;
            DMA_START: if (slot_end) state_next = DMA_XFER;
            DMA_XFER:  if (slot_end && last_byte) state_next = DMA_IDLE;
            default:   state_next = DMA_IDLE;
        endcase
        // A register write restarts the engine and wins over finishing.
        if (reg_write) begin
            state_next = DMA_START;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            dma_reg  <= 8'hFF;
            dma_byte <= 8'hFF;
        end else begin
            if (reg_write) begin
                dma_reg <= I_IOREG_WDATA;
            end
            // Router data for the phase-0 read is valid during phase 1.
            if ((state == DMA_XFER) && (phase == PHASE_W'(1))) begin
                dma_byte <= I_MEM_RDATA;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // Outputs hold their idle values while reset is asserted, so a reset
    // landing mid-transfer issues no further router strobes.
    always_comb begin
        O_MEM_ADDR   = '0;
        O_MEM_WDATA  = '0;
        O_MEM_WE_L   = 1'b1;
        O_MEM_RE_L   = 1'b1;
        O_CPU_RDATA  = 8'hFF;
        O_DMA_ACTIVE = 1'b0;
        if (!I_RESET) begin
            unique case (state)
                DMA_IDLE: begin
                    if (!cpu_is_io) begin
                        O_MEM_ADDR  = I_CPU_ADDR;
                        O_MEM_WDATA = I_CPU_WDATA;
                        O_MEM_WE_L  = I_CPU_WE_L;
                        O_MEM_RE_L  = I_CPU_RE_L;
                        O_CPU_RDATA = I_MEM_RDATA;
                    end
                end
                DMA_START: begin
                    O_DMA_ACTIVE = 1'b1;
                    O_CPU_RDATA  = blocked_rdata;
                end
                DMA_XFER: begin
                    O_DMA_ACTIVE = 1'b1;
                    O_CPU_RDATA  = blocked_rdata;
                    if (phase == PHASE_W'(0)) begin
                        O_MEM_RE_L = 1'b0;
                        O_MEM_ADDR = src_addr;
                    end else if (phase == PHASE_W'(2)) begin
                        O_MEM_WE_L  = 1'b0;
                        O_MEM_ADDR  = dest_addr;
                        O_MEM_WDATA = dma_byte;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// ----------------------------------------------------------------------------
// tb_oam_dma_controller
//   Bench for oam_dma_controller. A behavioural router memory answers the
//   DUT's bus; each DMA request pushes its expected source reads and OAM
//   writes into queues that a monitor drains as the DUT issues them.
// ----------------------------------------------------------------------------
module tb_oam_dma_controller;

    localparam int DMA_LEN       = 160;
    localparam int BYTE_CYCLES   = 4;
    localparam int ACTIVE_CYCLES = (DMA_LEN + 1) * BYTE_CYCLES;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic [15:0] I_IOREG_ADDR;
    logic [7:0]  I_IOREG_WDATA;
    logic        I_IOREG_WE_L;
    logic        I_IOREG_RE_L;
    logic [7:0]  O_IOREG_RDATA;
    logic [15:0] I_CPU_ADDR;
    logic [7:0]  I_CPU_WDATA;
    logic        I_CPU_WE_L;
    logic        I_CPU_RE_L;
    logic [7:0]  O_CPU_RDATA;
    logic [15:0] O_MEM_ADDR;
    logic [7:0]  O_MEM_WDATA;
    logic        O_MEM_WE_L;
    logic        O_MEM_RE_L;
    logic [7:0]  I_MEM_RDATA;
    logic        O_DMA_ACTIVE;

    always #5 I_CLK = ~I_CLK;

    oam_dma_controller dut (
        .I_CLK         (I_CLK),
        .I_RESET       (I_RESET),
        .I_IOREG_ADDR  (I_IOREG_ADDR),
        .I_IOREG_WDATA (I_IOREG_WDATA),
        .I_IOREG_WE_L  (I_IOREG_WE_L),
        .I_IOREG_RE_L  (I_IOREG_RE_L),
        .O_IOREG_RDATA (O_IOREG_RDATA),
        .I_CPU_ADDR    (I_CPU_ADDR),
        .I_CPU_WDATA   (I_CPU_WDATA),
        .I_CPU_WE_L    (I_CPU_WE_L),
        .I_CPU_RE_L    (I_CPU_RE_L),
        .O_CPU_RDATA   (O_CPU_RDATA),
        .O_MEM_ADDR    (O_MEM_ADDR),
        .O_MEM_WDATA   (O_MEM_WDATA),
        .O_MEM_WE_L    (O_MEM_WE_L),
        .O_MEM_RE_L    (O_MEM_RE_L),
        .I_MEM_RDATA   (I_MEM_RDATA),
        .O_DMA_ACTIVE  (O_DMA_ACTIVE)
    );

    // ------------------------------------------------- router memory model
    logic [7:0]  mem [65536];
    logic [7:0]  mem_rdata;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge I_CLK) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (!O_MEM_WE_L) mem[O_MEM_ADDR] <= O_MEM_WDATA;
        if (!O_MEM_RE_L) mem_rdata <= mem[O_MEM_ADDR];
    end
    assign I_MEM_RDATA = mem_rdata;

    // ------------------------------------------------- reference + scoreboard
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] rq[$];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  exp_oam [DMA_LEN];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          active_total = 0;

    function automatic logic [7:0] src_page(input logic [7:0] v);
        int p;
        p = int'(v);
        if (p >= 224) p = p - 32;
        return 8'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic preload_page(input logic [7:0] page, input bit pattern);
        logic [7:0] d;
        for (int i = 0; i < DMA_LEN; i++) begin
            d = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom_range(0, 255));
            bd_write({page, 8'(i)}, d);
        end
    endtask

    // Queue the reads/writes a transfer of n_bytes from register value v makes.
    task automatic expect_transfer(input logic [7:0] v, input int n_bytes);
        logic [15:0] s;
        for (int i = 0; i < n_bytes; i++) begin
            s = {src_page(v), 8'h00} + 16'(i);
            rq.push_back(s);
            wq.push_back(wr_t'{addr: 16'hFE00 + 16'(i), data: ref_mem[s]});
            exp_oam[i] = ref_mem[s];
        end
    endtask

    // Call while #1 after an edge; returns in the first cycle after the write.
    task automatic dma_write(input logic [7:0] v);
        I_IOREG_ADDR  = 16'hFF46;
        I_IOREG_WDATA = v;
        I_IOREG_WE_L  = 1'b0;
        tick();
        I_IOREG_WE_L  = 1'b1;
        I_IOREG_ADDR  = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge I_CLK);
            if (!O_DMA_ACTIVE) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check(name, 32'd0, 32'd1);
        tick();
    endtask

    task automatic check_oam(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < DMA_LEN; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // Expected CPU read data while the engine owns the bus, sampled in the
    // last phase of byte slot k (the byte for slot k has been fetched).
    function automatic logic [7:0] blocked_exp(input logic [7:0] v, input int k);
`ifdef OAM_DMA_BUS_CONFLICT_EN
        return ref_mem[{src_page(v), 8'h00} + 16'(k)];
`else
        if (k < 0 || v == 8'h00) return 8'hFF;
        return 8'hFF;
`endif
    endfunction

    task automatic blocked_read(input string name, input logic [7:0] v, input int k);
        I_CPU_ADDR = 16'hD000;
        I_CPU_RE_L = 1'b0;
        #1;
        check(name, O_CPU_RDATA, blocked_exp(v, k));
        check({name, "_strobe"}, O_MEM_RE_L, 1'b1);
        I_CPU_RE_L = 1'b1;
    endtask

    task automatic monitor();
        wr_t         e;
        logic [15:0] ra;
        forever begin
            @(negedge I_CLK);
            if (O_DMA_ACTIVE) active_total++;
            if (!I_RESET && O_DMA_ACTIVE) begin
                if (!O_MEM_WE_L) begin
                    if (wq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %h data %h, required none", O_MEM_ADDR, O_MEM_WDATA);
                    end else begin
                        e = wq.pop_front();
                        check("oam_write_addr", O_MEM_ADDR, e.addr);
                        check("oam_write_data", O_MEM_WDATA, e.data);
                    end
                end
                if (!O_MEM_RE_L) begin
                    if (rq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_read: got addr %h, required none", O_MEM_ADDR);
                    end else begin
                        ra = rq.pop_front();
                        check("src_read_addr", O_MEM_ADDR, ra);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int          t0;
        int          k;
        logic [7:0]  v;
        logic [7:0]  c000_val;

        I_RESET       = 1'b1;
        I_IOREG_ADDR  = '0;
        I_IOREG_WDATA = '0;
        I_IOREG_WE_L  = 1'b1;
        I_IOREG_RE_L  = 1'b1;
        I_CPU_ADDR    = '0;
        I_CPU_WDATA   = '0;
        I_CPU_WE_L    = 1'b1;
        I_CPU_RE_L    = 1'b1;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_data       = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge I_CLK);
        #1;
        check("rst_active",    O_DMA_ACTIVE, 1'b0);
        check("rst_mem_we",    O_MEM_WE_L,   1'b1);
        check("rst_mem_re",    O_MEM_RE_L,   1'b1);
        check("rst_mem_addr",  O_MEM_ADDR,   16'h0000);
        check("rst_mem_wdata", O_MEM_WDATA,  8'h00);
        check("rst_cpu_rdata", O_CPU_RDATA,  8'hFF);
        I_RESET = 1'b0;
        tick();
        I_IOREG_ADDR = 16'hFF46;
        I_IOREG_RE_L = 1'b0;
        #1;
        check("rst_dma_reg", O_IOREG_RDATA, 8'hFF);
        I_IOREG_RE_L = 1'b1;
        I_IOREG_ADDR = 16'h0000;

        // Source data
        preload_page(8'hC1, 1'b1);
        preload_page(8'hC2, 1'b0);
        preload_page(8'hC3, 1'b0);
        preload_page(8'hC4, 1'b0);
        c000_val = 8'($urandom_range(0, 255));
        bd_write(16'hC000, c000_val);
        bd_write(16'hC005, 8'($urandom_range(0, 255)));

        // Idle passthrough
        I_CPU_ADDR = 16'hC005;
        I_CPU_RE_L = 1'b0;
        #1;
        check("pt_read_strobe", O_MEM_RE_L, 1'b0);
        check("pt_read_addr",   O_MEM_ADDR, 16'hC005);
        tick();
        check("pt_read_data",   O_CPU_RDATA, ref_mem[16'hC005]);
        I_CPU_RE_L  = 1'b1;
        I_CPU_ADDR  = 16'hC006;
        I_CPU_WDATA = 8'hA5;
        I_CPU_WE_L  = 1'b0;
        #1;
        check("pt_write_strobe", O_MEM_WE_L, 1'b0);
        tick();
        I_CPU_WE_L = 1'b1;
        check("pt_write_mem", mem[16'hC006], 8'hA5);
        ref_mem[16'hC006] = 8'hA5;
        I_CPU_ADDR = 16'hFF80;
        I_CPU_RE_L = 1'b0;
        I_CPU_WE_L = 1'b0;
        #1;
        check("io_page_re_blocked", O_MEM_RE_L, 1'b1);
        check("io_page_we_blocked", O_MEM_WE_L, 1'b1);
        I_CPU_RE_L = 1'b1;
        I_CPU_WE_L = 1'b1;
        I_CPU_ADDR = 16'h0000;
        tick();

        // Full transfer from 0xC100 with CPU interference mid-transfer
        expect_transfer(8'hC1, DMA_LEN);
        t0 = active_total;
        dma_write(8'hC1);
        repeat (47) tick();                 // slot 10, last phase
        I_CPU_ADDR  = 16'hC000;
        I_CPU_WDATA = 8'h77;
        I_CPU_WE_L  = 1'b0;
        tick();
        I_CPU_WE_L  = 1'b1;
        repeat (3) tick();                  // slot 11, last phase
        blocked_read("blocked_read_c1", 8'hC1, 11);
        I_CPU_ADDR = 16'h0000;
        wait_idle("idle_timeout_c1");
        check("active_len_c1", 32'(active_total - t0), 32'(ACTIVE_CYCLES));
        check("cpu_write_dropped", mem[16'hC000], c000_val);
        check_oam("oam_c1");

        // Echo-RAM folding: 0xE2 fetches from 0xC200
        expect_transfer(8'hE2, DMA_LEN);
        t0 = active_total;
        dma_write(8'hE2);
        repeat (20) tick();
        I_IOREG_ADDR = 16'hFF46;
        I_IOREG_RE_L = 1'b0;
        #1;
        check("dma_reg_readback", O_IOREG_RDATA, 8'hE2);
        I_IOREG_RE_L = 1'b1;
        I_IOREG_ADDR = 16'h0000;
        wait_idle("idle_timeout_e2");
        check("active_len_e2", 32'(active_total - t0), 32'(ACTIVE_CYCLES));
        check_oam("oam_e2");

        // Restart at slot 50 with 0xC3
        expect_transfer(8'hC4, 50);
        expect_transfer(8'hC3, DMA_LEN);
        t0 = active_total;
        dma_write(8'hC4);
        repeat (203) tick();                // last cycle of slot 49
        dma_write(8'hC3);
        wait_idle("idle_timeout_restart");
        check("active_len_restart", 32'(active_total - t0), 32'(50 * 4 + 4 + ACTIVE_CYCLES));
        check_oam("oam_restart");

        // Reset at slot 80
        v = 8'($urandom_range(0, 255));
        preload_page(src_page(v), 1'b0);
        expect_transfer(v, 80);
        dma_write(v);
        repeat (4 + 4 * 80) tick();         // first cycle of slot 80
        I_RESET = 1'b1;
        tick();
        I_RESET = 1'b0;
        check("rst_abort_active", O_DMA_ACTIVE, 1'b0);
        I_IOREG_ADDR = 16'hFF46;
        I_IOREG_RE_L = 1'b0;
        #1;
        check("rst_abort_dma_reg", O_IOREG_RDATA, 8'hFF);
        I_IOREG_RE_L = 1'b1;
        I_IOREG_ADDR = 16'h0000;
        repeat (20) tick();
        check("rst_abort_stays_idle", O_DMA_ACTIVE, 1'b0);
        check_oam("oam_after_reset");

        // Randomised transfers with a blocked read at a random slot
        for (int r = 0; r < 2; r++) begin
            v = 8'($urandom_range(0, 255));
            preload_page(src_page(v), 1'b0);
            expect_transfer(v, DMA_LEN);
            k = $urandom_range(1, DMA_LEN - 1);
            t0 = active_total;
            dma_write(v);
            repeat (4 + 4 * k + 3) tick();
            blocked_read("blocked_read_rand", v, k);
            I_CPU_ADDR = 16'h0000;
            wait_idle("idle_timeout_rand");
            check("active_len_rand", 32'(active_total - t0), 32'(ACTIVE_CYCLES));
            check_oam("oam_rand");
        end

        check("write_queue_drained", 32'(wq.size()), 32'd0);
        check("read_queue_drained",  32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
